// File: rtl/mult_shift_add.sv
// -----------------------------------------------------------------------------
// mult_shift_add
//   Iterative signed WIDTH x WIDTH shift-and-add multiplier for the ALU
//   multdiv path. Operands are converted to sign + magnitude on the start
//   edge. One multiplier bit is consumed per clock. The signed product is
//   formed in a single DONE cycle.
//
//   Also contains mult_shift_add_sll1, the one-bit left-shift stage that
//   advances the double-width multiplicand each iteration.
//
// Ports (mult_shift_add):
//   clock           in   rising-edge clock
//   reset           in   asynchronous, active-low reset
//   ctrl_MULT       in   start pulse; operands sampled on the same edge
//   data_operandA   in   multiplicand, two's complement
//   data_operandB   in   multiplier, two's complement
//   data_result     out  low WIDTH bits of the signed product (held)
//   data_exception  out  product does not fit in signed WIDTH bits (held)
//   data_resultRDY  out  one-cycle pulse when the result is valid
//   busy            out  high while iterating
// -----------------------------------------------------------------------------

// One-bit left shift of a WIDTH-bit slice: shift_in_i enters at bit 0 and the
// old MSB leaves on shift_out_o so that slices can be chained.
module mult_shift_add_sll1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_in_i,
    output logic [WIDTH-1:0] data_o,
    output logic             shift_out_o
);

    assign data_o      = {data_i[WIDTH-2:0], shift_in_i};
    assign shift_out_o = data_i[WIDTH-1];

endmodule

module mult_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Unsigned magnitude; the most negative value maps onto itself, which is
    // exactly its magnitude when read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // True when every bit of the vector has the same value.
    function automatic logic all_equal(input logic [WIDTH:0] v);
        all_equal = (&v) | ~(|v);
    endfunction

    state_e                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [2*WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   exc_q, exc_d;
    logic                   rdy_q, rdy_d;
    logic                   busy_q, busy_d;

    logic [WIDTH-1:0]       m_lo_sh_s, m_hi_sh_s;
    logic                   m_lo_carry_s;
    logic                   m_unused_carry_s;
    logic [2*WIDTH-1:0]     prod_s;

    // Multiplicand advance: low half feeds its MSB into the high half.
    mult_shift_add_sll1 #(.WIDTH(WIDTH)) u_sll_lo (
        .data_i      (m_q[WIDTH-1:0]),
        .shift_in_i  (1'b0),
        .data_o      (m_lo_sh_s),
        .shift_out_o (m_lo_carry_s)
    );

    // The top bit shifted out is always zero because |A| < 2^WIDTH and at most
    // WIDTH-1 shifts are ever accumulated.
    mult_shift_add_sll1 #(.WIDTH(WIDTH)) u_sll_hi (
        .data_i      (m_q[2*WIDTH-1:WIDTH]),
        .shift_in_i  (m_lo_carry_s),
        .data_o      (m_hi_sh_s),
        .shift_out_o (m_unused_carry_s)
    );

    // Apply the latched sign to the unsigned product.
    always_comb begin
        prod_s = acc_q;
        if (sign_q) begin
            prod_s = ~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            prod_s = acc_q;
        end
    end

    // Next-state and datapath control; a start request overrides every state.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        m_d      = m_q;
        q_d      = q_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        busy_d   = busy_q;

        if (ctrl_MULT) begin
            sign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            m_d     = {{WIDTH{1'b0}}, magnitude(data_operandA)};
            q_d     = magnitude(data_operandB);
            acc_d   = {(2*WIDTH){1'b0}};
            count_d = {CW{1'b0}};
            busy_d  = 1'b1;
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                end
                RUN: begin
                    if (q_q[0]) begin
                        acc_d = acc_q + m_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    m_d     = {m_hi_sh_s, m_lo_sh_s};
                    q_d     = {1'b0, q_q[WIDTH-1:1]};
                    count_d = count_q + CNT_ONE;
                    if (count_q == CNT_LAST) begin
                        // busy covers only the WIDTH iteration cycles.
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
                DONE: begin
                    result_d = prod_s[WIDTH-1:0];
                    exc_d    = ~all_equal(prod_s[2*WIDTH-1:WIDTH-1]);
                    rdy_d    = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            m_q      <= {(2*WIDTH){1'b0}};
            q_q      <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            count_q  <= {CW{1'b0}};
            result_q <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            m_q      <= m_d;
            q_q      <= q_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_mult_shift_add.sv
module tb_mult_shift_add;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int total;
    int bad;

    mult_shift_add #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Issue a start pulse; returns 1 ns after the start edge.
    task automatic start_only(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
    endtask

    // Start an operation and collect what the DUT shows up to the first RDY.
    task automatic mul_and_wait(input logic [31:0] a, input logic [31:0] b,
                                output logic seen, output int lat,
                                output logic [31:0] res, output logic exc,
                                output int busy_cnt, output logic rdy_at_start);
        seen = 1'b0;
        lat = 0;
        res = 32'h0;
        exc = 1'b0;
        start_only(a, b);
        rdy_at_start = data_resultRDY;
        busy_cnt = busy ? 1 : 0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(posedge clock);
            #1;
            if (busy) busy_cnt++;
            if (data_resultRDY) begin
                seen = 1'b1;
                lat  = n;
                res  = data_result;
                exc  = data_exception;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        #2;
        total++; if (data_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=%h", data_result, 32'h0); end
        total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b want=0", data_exception); end
        total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", data_resultRDY); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_positive;
        logic seen, exc, r0; int lat, bc; logic [31:0] res;
        mul_and_wait(32'd7, 32'd6, seen, lat, res, exc, bc, r0);
        total++; if (!seen) begin bad++; $display("FAIL pos_rdy_timeout got=none want=rdy"); end
        total++; if (lat !== 33) begin bad++; $display("FAIL pos_latency got=%0d want=33", lat); end
        total++; if (res !== 32'd42) begin bad++; $display("FAIL pos_result got=%h want=%h", res, 32'd42); end
        total++; if (exc !== 1'b0) begin bad++; $display("FAIL pos_exc got=%b want=0", exc); end
        total++; if (bc !== 32) begin bad++; $display("FAIL pos_busy_cycles got=%0d want=32", bc); end
        @(posedge clock); #1;
        total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL pos_rdy_pulse got=%b want=0", data_resultRDY); end
        total++; if (data_result !== 32'd42) begin bad++; $display("FAIL pos_result_hold got=%h want=%h", data_result, 32'd42); end
    endtask

    task automatic test_signed;
        logic seen, exc, r0; int lat, bc; logic [31:0] res;
        mul_and_wait(32'hFFFFFFFD, 32'd5, seen, lat, res, exc, bc, r0);
        total++; if (!seen || res !== 32'hFFFFFFF1) begin bad++; $display("FAIL neg3x5_result got=%h want=%h", res, 32'hFFFFFFF1); end
        total++; if (exc !== 1'b0) begin bad++; $display("FAIL neg3x5_exc got=%b want=0", exc); end
        mul_and_wait(32'hFFFFFFFC, 32'hFFFFFFFC, seen, lat, res, exc, bc, r0);
        total++; if (!seen || res !== 32'd16) begin bad++; $display("FAIL neg4xneg4_result got=%h want=%h", res, 32'd16); end
        total++; if (exc !== 1'b0) begin bad++; $display("FAIL neg4xneg4_exc got=%b want=0", exc); end
    endtask

    task automatic test_boundary;
        logic seen, exc, r0; int lat, bc; logic [31:0] res;
        mul_and_wait(32'h80000000, 32'd1, seen, lat, res, exc, bc, r0);
        total++; if (!seen || res !== 32'h80000000) begin bad++; $display("FAIL min_x1_result got=%h want=%h", res, 32'h80000000); end
        total++; if (exc !== 1'b0) begin bad++; $display("FAIL min_x1_exc got=%b want=0", exc); end
        mul_and_wait(32'h80000000, 32'hFFFFFFFF, seen, lat, res, exc, bc, r0);
        total++; if (!seen || res !== 32'h80000000) begin bad++; $display("FAIL min_xneg1_result got=%h want=%h", res, 32'h80000000); end
        total++; if (exc !== 1'b1) begin bad++; $display("FAIL min_xneg1_exc got=%b want=1", exc); end
        mul_and_wait(32'h00010000, 32'h00010000, seen, lat, res, exc, bc, r0);
        total++; if (!seen || res !== 32'h0) begin bad++; $display("FAIL 2p16sq_result got=%h want=%h", res, 32'h0); end
        total++; if (exc !== 1'b1) begin bad++; $display("FAIL 2p16sq_exc got=%b want=1", exc); end
    endtask

    task automatic test_abort;
        logic seen, exc, r0; int lat, bc; logic [31:0] res; int early;
        early = 0;
        start_only(32'd3, 32'd3);
        // Held outputs from the previous operation survive a new start.
        total++; if (data_exception !== 1'b1) begin bad++; $display("FAIL abort_exc_hold got=%b want=1", data_exception); end
        for (int i = 0; i < 9; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) early++;
        end
        mul_and_wait(32'd2, 32'd5, seen, lat, res, exc, bc, r0);
        total++; if (early !== 0) begin bad++; $display("FAIL abort_early_rdy got=%0d want=0", early); end
        total++; if (lat !== 33) begin bad++; $display("FAIL abort_latency got=%0d want=33", lat); end
        total++; if (!seen || res !== 32'd10) begin bad++; $display("FAIL abort_result got=%h want=%h", res, 32'd10); end
    endtask

    task automatic test_reset_mid;
        logic seen, exc, r0; int lat, bc; logic [31:0] res; int rdy_cnt;
        rdy_cnt = 0;
        start_only(32'd100, 32'd100);
        repeat (14) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        total++; if (data_result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h want=%h", data_result, 32'h0); end
        total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL rstmid_exc got=%b want=0", data_exception); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL rstmid_rdy got=%b want=0", data_resultRDY); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY || busy) rdy_cnt++;
        end
        total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL rstmid_idle_after got=%0d want=0", rdy_cnt); end
        mul_and_wait(32'd9, 32'd9, seen, lat, res, exc, bc, r0);
        total++; if (!seen || res !== 32'd81) begin bad++; $display("FAIL rstmid_9x9 got=%h want=%h", res, 32'd81); end
    endtask

    task automatic test_zero;
        logic seen, exc, r0; int lat, bc; logic [31:0] res;
        mul_and_wait(32'h0, 32'hFFFFFFF9, seen, lat, res, exc, bc, r0);
        total++; if (!seen || res !== 32'h0) begin bad++; $display("FAIL zero_result got=%h want=%h", res, 32'h0); end
        total++; if (exc !== 1'b0) begin bad++; $display("FAIL zero_exc got=%b want=0", exc); end
    endtask

    task automatic test_back_to_back;
        logic seen, exc, r0; int lat, bc; logic [31:0] res;
        start_only(32'd6, 32'd7);
        repeat (32) @(posedge clock);
        // Second start lands on the edge that would have raised RDY for 6*7.
        mul_and_wait(32'd11, 32'd13, seen, lat, res, exc, bc, r0);
        total++; if (r0 !== 1'b0) begin bad++; $display("FAIL b2b_first_rdy got=%b want=0", r0); end
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
        total++; if (!seen || res !== 32'd143) begin bad++; $display("FAIL b2b_result got=%h want=%h", res, 32'd143); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_positive;
        test_signed;
        test_boundary;
        test_abort;
        test_reset_mid;
        test_zero;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_shift_add.md
Name: mult_shift_add

Overview:
- Iterative signed 32x32 multiplier for the ALU's multdiv path. Shift-and-add, one multiplier bit per clock.
- Sits directly downstream of the one-bit left-shift stage. That stage is instantiated here to advance the multiplicand each iteration.
- Result goes to the writeback mux, with a one-cycle ready pulse and an overflow exception flag.

Parameters:
- WIDTH, 32, operand/result width. Internal accumulator is 2*WIDTH. Iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ctrl_MULT  input  1  start pulse; operands sampled on the same edge
- data_operandA  input  WIDTH  multiplicand, two's complement
- data_operandB  input  WIDTH  multiplier, two's complement
- data_result  output  WIDTH  low WIDTH bits of the signed product
- data_exception  output  1  product does not fit in signed WIDTH bits
- data_resultRDY  output  1  one-cycle pulse when result is valid
- busy  output  1  high while iterating

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, asynchronous): state=IDLE. data_result=0, data_exception=0, data_resultRDY=0, busy=0. Accumulator, counter and operand registers are cleared.
- States: IDLE, RUN, DONE.
- Start (any state, ctrl_MULT=1 at an edge):
  - Latch sign = A[31]^B[31].
  - Latch magnitudes |A| and |B| as unsigned WIDTH-bit values. -2^31 maps to 0x80000000 unchanged.
  - M = zero-extend(|A|) to 2*WIDTH; Q = |B|; acc = 0; count = 0.
  - busy=1, data_resultRDY=0, state=RUN.
- RUN, each cycle:
  - If Q[0], acc <= acc + M.
  - M <= M shifted left one bit, using the one-bit left-shift stage on both halves. Low-half bit WIDTH-1 feeds the high half's bit 0; zero enters at bit 0.
  - Q <= Q >> 1 (logical); count <= count + 1.
  - After the iteration with count == WIDTH-1, go to DONE.
- DONE (single cycle):
  - p = sign ? -acc : acc, computed in 2*WIDTH bits.
  - data_result <= p[WIDTH-1:0].
  - data_exception <= 1 iff bits p[2*WIDTH-1:WIDTH-1] are not all equal.
  - data_resultRDY <= 1 for exactly this cycle; busy <= 0; state <= IDLE.
- Latency: start at edge 0 → data_resultRDY high in the cycle after edge WIDTH+1 (33 for WIDTH=32). Latency is fixed; there is no early termination.
- Outputs hold: data_result and data_exception hold their last values until the next DONE. They are not cleared at start.
- ctrl_MULT during RUN or DONE aborts the current operation and restarts with the new operands. The aborted result is never reported and no RDY pulse is produced for it.
- ctrl_MULT in the same cycle as DONE: the restart wins, and RDY for the old operation is suppressed.
- Zero product: result 0 and exception 0 regardless of sign.
- Overflow: data_result still carries the truncated low bits.
- Reset asserted mid-RUN: immediate return to reset values; no RDY pulse.
- Operand inputs are ignored except on the start edge.

Test Plan:
- Positive operands: A=7, B=6 → RDY exactly 33 cycles after start; result=42, exception=0, busy high for 32 cycles.
- Signed cases:
  - A=-3, B=5 → result=0xFFFFFFF1, exception=0.
  - A=-4, B=-4 → result=16, exception=0.
- Boundaries:
  - A=0x80000000, B=1 → result=0x80000000, exception=0.
  - A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1.
  - A=0x10000, B=0x10000 → result=0, exception=1.
- Abort: start A=3, B=3; 10 cycles later start A=2, B=5. Single RDY 33 cycles after the second start, result=10; no RDY for the first operation.
- Reset mid-RUN: assert reset at cycle 15. All outputs are 0 within the same cycle, no RDY, busy=0. A following start with A=9, B=9 gives result=81.
- Zero/sign: A=0, B=-7 → result=0, exception=0. Back-to-back start issued in the RDY cycle → first RDY suppressed, second result correct.
